state_dump_unit: RTL and testbench

- Hardware replacement for the bench-side register and data-memory dump of the single-cycle core.
- On command it halts the core and walks the register file and then the data memory, one word per beat.
- Each word leaves through a valid/ready stream to a UART or trace sink.
- Sits beside the core; drives the core's debug read ports while the core is halted.

---
 rtl/state_dump_unit.sv | 185 ++++++++++++++++++
 tb/tb_state_dump_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/state_dump_unit.sv
// Halts the core, then streams its register file and data memory one word per beat over valid/ready.
// Optional checksum beat after the data words: define STATE_DUMP_CHECKSUM_EN.
module state_dump_unit #(
   parameter int          WIDTH  = 32,
   parameter int          NREGS  = 32,
   parameter int          SIZE   = 1024,
   parameter logic [31:0] OFFSET = 32'h0,
   parameter int          IDX_W  = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     start,
   input  logic [1:0]               sel,
   output logic                     halt_req,
   input  logic                     halt_ack,
   output logic [$clog2(NREGS)-1:0] reg_addr,
   input  logic [WIDTH-1:0]         reg_data,
   output logic [31:0]              mem_addr,
   input  logic [WIDTH-1:0]         mem_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [1:0]               out_tag,
   output logic [IDX_W-1:0]         out_index,
   output logic                     busy,
   output logic                     done,
   output logic                     abort
);

   localparam int RA_W = $clog2(NREGS);

`ifdef STATE_DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, HALT, REGS, MEM, SUM, FIN} state_t;
   localparam state_t AFTER_DATA = SUM;
   logic [WIDTH-1:0] sum;
`else
   typedef enum logic [2:0] {IDLE, HALT, REGS, MEM, FIN} state_t;
   localparam state_t AFTER_DATA = FIN;
`endif

   state_t           state;
   state_t           state_next;
   logic [1:0]       sel_latched;
   logic [IDX_W-1:0] count;
   logic             load_slot;
   logic             streaming;
   logic             lost_ack;
   logic             beat;
   logic             last_reg;
   logic             last_mem;

   assign load_slot = !out_valid || out_ready;
   assign last_reg  = (count == IDX_W'(NREGS - 1));
   assign last_mem  = (count == IDX_W'(SIZE - 1));

`ifdef STATE_DUMP_CHECKSUM_EN
   assign streaming = (state == REGS) || (state == MEM) || (state == SUM);
   assign lost_ack  = (streaming || (state == FIN)) && !halt_ack;
`else
   assign streaming = (state == REGS) || (state == MEM);
   assign lost_ack  = (streaming || (state == FIN)) && !halt_ack;
`endif

   // A beat is only taken while the core is still confirmed frozen.
   assign beat = streaming && halt_ack && load_slot;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) state_next = HALT;
         end
         HALT: begin
            if (halt_ack) begin
               if (sel_latched[0])      state_next = REGS;
               else if (sel_latched[1]) state_next = MEM;
               else                     state_next = AFTER_DATA;
            end
         end
         REGS: begin
            if (!halt_ack)
               state_next = IDLE;
            else if (beat && last_reg)
               state_next = sel_latched[1] ? MEM : AFTER_DATA;
         end
         MEM: begin
            if (!halt_ack)              state_next = IDLE;
            else if (beat && last_mem)  state_next = AFTER_DATA;
         end
`ifdef STATE_DUMP_CHECKSUM_EN
         SUM: begin
            if (!halt_ack)  state_next = IDLE;
            else if (beat)  state_next = FIN;
         end
`endif
         FIN: begin
            if (!halt_ack || !out_valid) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      done     = (state == FIN) && halt_ack && !out_valid;
      abort    = lost_ack;
      busy     = (state != IDLE) && !done && !abort;
      halt_req = busy;
      reg_addr = '0;
      mem_addr = '0;
      if (state == REGS) reg_addr = count[RA_W-1:0];
      if (state == MEM)  mem_addr = OFFSET + (32'(count) << 2);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sel_latched <= '0;
         count       <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_tag     <= '0;
         out_index   <= '0;
`ifdef STATE_DUMP_CHECKSUM_EN
         sum         <= '0;
`endif
      end else begin
         if (state == IDLE && start) begin
            sel_latched <= sel;
`ifdef STATE_DUMP_CHECKSUM_EN
            sum         <= '0;
`endif
         end

         // Every phase change restarts the word counter, so nothing leaks between dumps.
         if (state_next != state)
            count <= '0;
         else if (beat)
            count <= count + 1'b1;

         if (lost_ack) begin
            out_valid <= 1'b0;
         end else if (beat) begin
            out_valid <= 1'b1;
            case (state)
               REGS: begin
                  out_data  <= reg_data;
                  out_tag   <= 2'd0;
                  out_index <= count;
`ifdef STATE_DUMP_CHECKSUM_EN
                  sum       <= sum + reg_data;
`endif
               end
               MEM: begin
                  out_data  <= mem_data;
                  out_tag   <= 2'd1;
                  out_index <= count;
`ifdef STATE_DUMP_CHECKSUM_EN
                  sum       <= sum + mem_data;
`endif
               end
`ifdef STATE_DUMP_CHECKSUM_EN
               SUM: begin
                  out_data  <= sum;
                  out_tag   <= 2'd2;
                  out_index <= '0;
               end
`endif
               default: begin
                  out_data  <= out_data;
               end
            endcase
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_state_dump_unit.sv
// Randomized bench for state_dump_unit: a queue-based model of the expected beat stream plus a simple core/memory model.
module tb_state_dump_unit;
   localparam int          WIDTH  = 32;
   localparam int          NREGS  = 32;
   localparam int          SIZE   = 16;
   localparam int          IDX_W  = 16;
   localparam logic [31:0] OFFSET = 32'hFFFF_FFE0;  // memory window wraps past 2**32

   logic              CLK = 1'b0;
   logic              RST;
   logic              start;
   logic [1:0]        sel;
   logic              halt_req;
   logic              halt_ack;
   logic [4:0]        reg_addr;
   logic [WIDTH-1:0]  reg_data;
   logic [31:0]       mem_addr;
   logic [WIDTH-1:0]  mem_data;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic [1:0]        out_tag;
   logic [IDX_W-1:0]  out_index;
   logic              busy;
   logic              done;
   logic              abort;

   logic [31:0] regs [NREGS];
   logic [31:0] mem_words [SIZE];
   logic        hreq_prev;
   int          tests = 0;
   int          failures = 0;

   state_dump_unit #(
      .WIDTH(WIDTH), .NREGS(NREGS), .SIZE(SIZE), .OFFSET(OFFSET), .IDX_W(IDX_W)
   ) dut (
      .CLK(CLK), .RST(RST), .start(start), .sel(sel),
      .halt_req(halt_req), .halt_ack(halt_ack),
      .reg_addr(reg_addr), .reg_data(reg_data),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .out_index(out_index),
      .busy(busy), .done(done), .abort(abort)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      logic [31:0] off;
      int          idx;
      off = a - OFFSET;
      idx = int'(off >> 2);
      if (off[1:0] == 2'b00 && off < 32'(SIZE * 4)) return mem_words[idx];
      return 32'hBAD0_0000 ^ a;
   endfunction

   assign reg_data = regs[reg_addr];
   assign mem_data = mem_read(mem_addr);

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_a"}, {out_data, mem_addr}, 64'd0);
      check({name, "_b"}, 64'({halt_req, reg_addr, out_valid, out_tag, out_index, busy, done, abort}), 64'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK);
         start     = 1'b0;
         halt_ack  = hreq_prev;
         out_ready = 1'b1;
         #1;
         hreq_prev = halt_req;
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
      for (int k = 0; k < SIZE; k++) mem_words[k] = $urandom;
   endtask

   // mode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random ready
   task automatic run_dump(input logic [1:0] s, input int mode, input int abort_at,
                           input int rst_at, input int restart_at);
      logic [63:0] expq[$];
      logic [63:0] got;
      logic [63:0] prev_beat = '0;
      logic [31:0] sum = '0;
      int n_acc = 0, ack_cyc = -1, first_v = -1, first_b = -1, last_b = -1;
      int done_cyc = -1, dones = 0, aborts = 0, nbeats;
      bit drop = 0, fin = 0, restart_now = 0, restarted = 0, prev_stall = 0, did_rst = 0;

      if (s[0]) for (int i = 0; i < NREGS; i++) begin
         expq.push_back({14'd0, 2'd0, 16'(i), regs[i]});
         sum += regs[i];
      end
      if (s[1]) for (int k = 0; k < SIZE; k++) begin
         expq.push_back({14'd0, 2'd1, 16'(k), mem_words[k]});
         sum += mem_words[k];
      end
`ifdef STATE_DUMP_CHECKSUM_EN
      expq.push_back({14'd0, 2'd2, 16'd0, sum});
`endif
      nbeats = expq.size();

      for (int c = 0; c < 600 && !fin; c++) begin
         @(negedge CLK);
         start = (c == 0) || restart_now;
         sel   = restart_now ? ~s : s;
         if (restart_now) restarted = 1;
         restart_now = 0;
         halt_ack = hreq_prev && !drop;
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (halt_ack && ack_cyc < 0) ack_cyc = c;
         if (out_valid && first_v < 0) first_v = c;
         got = {14'd0, out_tag, out_index, out_data};
         if (prev_stall) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_hold", got, prev_beat);
         end
         prev_stall = out_valid && !out_ready && !abort;
         prev_beat  = got;
         if (out_valid && out_ready && !abort) begin
            if (expq.size() == 0) check("beat_count", 64'(n_acc + 1), 64'(nbeats));
            else check("beat", got, expq.pop_front());
            n_acc++;
            if (first_b < 0) first_b = c;
            last_b = c;
            if (abort_at > 0 && n_acc == abort_at) drop = 1;
            if (restart_at > 0 && n_acc == restart_at && !restarted) restart_now = 1;
            if (rst_at > 0 && n_acc == rst_at) begin
               #1 RST = 1'b1;
               #1 check_all_zero("rst_mid_dump");
               did_rst = 1;
               fin = 1;
            end
         end
         if (done) begin
            dones++;
            done_cyc = c;
            check("done_halt_req", 64'(halt_req), 64'd0);
            check("done_busy", 64'(busy), 64'd0);
            fin = 1;
         end
         if (abort) begin
            aborts++;
            check("abort_halt_req", 64'(halt_req), 64'd0);
            check("abort_busy", 64'(busy), 64'd0);
            fin = 1;
         end
         hreq_prev = halt_req;
      end
      check("dump_finished", 64'(fin), 64'd1);

      if (did_rst) begin
         @(posedge CLK);
         @(negedge CLK);
         RST = 1'b0; start = 1'b0; halt_ack = 1'b0; hreq_prev = 1'b0;
         $display("[TB] dump sel=%0d mode=%0d reset after %0d beats", s, mode, n_acc);
         return;
      end

      @(negedge CLK);
      start = 1'b0; halt_ack = hreq_prev; out_ready = 1'b1;
      #1;
      if (abort_at > 0) begin
         check("abort_valid_clr", 64'(out_valid), 64'd0);
         check("abort_once", 64'(abort), 64'd0);
         check("abort_count", 64'(aborts), 64'd1);
         check("abort_no_done", 64'(dones), 64'd0);
         check("abort_beats", 64'(n_acc), 64'(abort_at));
      end else begin
         check("done_once", 64'(done), 64'd0);
         check("done_count", 64'(dones), 64'd1);
         check("beats", 64'(n_acc), 64'(nbeats));
         check("idle_busy", 64'(busy), 64'd0);
         if (s != 2'b00) check("first_latency", 64'(first_v - ack_cyc), 64'd2);
`ifndef STATE_DUMP_CHECKSUM_EN
         else check("sel0_latency", 64'(done_cyc - ack_cyc), 64'd1);
`endif
         if (mode == 0 && nbeats > 0) check("gapless", 64'(last_b - first_b), 64'(nbeats - 1));
      end
      hreq_prev = halt_req;
      $display("[TB] dump sel=%0d mode=%0d beats=%0d/%0d done=%0d abort=%0d",
               s, mode, n_acc, nbeats, dones, aborts);
   endtask

   initial begin
      RST = 1'b1; start = 1'b0; sel = 2'b00; halt_ack = 1'b0; out_ready = 1'b1;
      hreq_prev = 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] = 32'(i * 3);
      for (int k = 0; k < SIZE; k++) mem_words[k] = 32'h100 + 32'(k);
      repeat (3) @(negedge CLK);
      #1 check_all_zero("reset_state");
      RST = 1'b0;
      idle(2);

      run_dump(2'b11, 0, 0, 0, 0);   // full dump, ready high
      idle(3);
      run_dump(2'b11, 1, 0, 0, 0);   // ready pattern 1,0,0,1
      idle(3);
      fill_random();
      run_dump(2'b10, 2, 0, 0, 0);   // memory only
      idle(3);
      run_dump(2'b11, 0, 10, 0, 0);  // core drops halt_ack after 10 beats
      idle(3);
      run_dump(2'b11, 2, 0, 0, 0);   // fresh dump after abort
      idle(3);
      run_dump(2'b10, 0, 0, 5, 0);   // reset in the memory phase
      idle(3);
      run_dump(2'b11, 2, 0, 0, 5);   // start while busy must be ignored
      idle(3);
      run_dump(2'b00, 0, 0, 0, 0);   // nothing selected
      idle(3);
      run_dump(2'b01, 2, 0, 0, 0);   // registers only
      for (int t = 0; t < 3; t++) begin
         idle(2);
         fill_random();
         run_dump(2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0, 0, 0);
      end
      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule
